// File: rtl/data_memory_mc.sv
// Word-addressed data memory: a CPU read/write port with byte enables, plus a
// round-robin arbitrated read port shared by NUM_RD read-only clients.
module data_memory_mc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int NUM_RD   = 2,
  parameter     MEM_INIT = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_we,
  input  logic [DATA_W/8-1:0]   cpu_be,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wd,
  output logic [DATA_W-1:0]     cpu_rd,
  output logic                  cpu_err,
  input  logic [NUM_RD-1:0]     rd_req,
  input  logic [NUM_RD*32-1:0]  rd_addr,
  output logic [NUM_RD-1:0]     rd_gnt,
  output logic [NUM_RD-1:0]     rd_valid,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int RR_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  // Power-up contents are undefined; MEM_INIT names the image the memory
  // generator preloads into the array outside of this RTL.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [DATA_W-1:0] r_cpu_rd;
  logic              r_cpu_err;
  logic [NUM_RD-1:0] r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [RR_W-1:0]   r_rr;

  logic [ADDR_W-1:0] w_cpu_idx;
  logic              w_cpu_oor;
  logic              w_cpu_wr;
  logic [NUM_RD-1:0] w_gnt;
  logic              w_gnt_found;
  logic [RR_W-1:0]   w_gnt_k;
  logic [RR_W-1:0]   w_rr_next;
  logic [31:0]       w_gnt_addr;
  logic [ADDR_W-1:0] w_gnt_idx;
  logic              w_gnt_oor;
  logic              w_fwd;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused_ok;

  assign w_cpu_idx = cpu_addr[ADDR_W+1:2];
  assign w_cpu_oor = |cpu_addr[31:ADDR_W+2];
  // Writes are blocked while reset is held; the array itself is never reset.
  assign w_cpu_wr  = rst && cpu_we && !w_cpu_oor;

  always_ff @(posedge clk) begin
    if (w_cpu_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (cpu_be[b]) r_mem[w_cpu_idx][b*8 +: 8] <= cpu_wd[b*8 +: 8];
      end
    end
  end

  // CPU read is read-first: the array read here sees the pre-write word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rd  <= '0;
      r_cpu_err <= 1'b0;
    end else begin
      r_cpu_rd  <= w_cpu_oor ? '0 : r_mem[w_cpu_idx];
      r_cpu_err <= w_cpu_oor;
    end
  end

  // Client handshake: a client raises rd_req with rd_addr and holds both
  // stable until rd_gnt is seen in the same cycle; the address is taken on
  // that edge and rd_valid (one-hot) qualifies rd_data on the next cycle.
  always_comb begin
    int k;
    w_gnt       = '0;
    w_gnt_found = 1'b0;
    w_gnt_k     = '0;
    k           = 0;
    for (int off = 0; off < NUM_RD; off++) begin
      k = (int'(r_rr) + off) % NUM_RD;
      if (rst && !w_gnt_found && rd_req[k]) begin
        w_gnt[k]    = 1'b1;
        w_gnt_found = 1'b1;
        w_gnt_k     = k[RR_W-1:0];
      end
    end
  end

  assign w_rr_next  = (w_gnt_k == RR_W'(NUM_RD - 1)) ? '0 : w_gnt_k + 1'b1;
  assign w_gnt_addr = rd_addr[int'(w_gnt_k)*32 +: 32];
  assign w_gnt_idx  = w_gnt_addr[ADDR_W+1:2];
  assign w_gnt_oor  = |w_gnt_addr[31:ADDR_W+2];
  assign w_fwd      = w_cpu_wr && !w_gnt_oor && (w_cpu_idx == w_gnt_idx);

  // Same-cycle CPU write to the granted word is merged lane by lane.
  always_comb begin
    w_rd_word = r_mem[w_gnt_idx];
    if (w_fwd) begin
      for (int b = 0; b < NB; b++) begin
        if (cpu_be[b]) w_rd_word[b*8 +: 8] = cpu_wd[b*8 +: 8];
      end
    end
    if (w_gnt_oor) w_rd_word = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_rr       <= '0;
    end else begin
      r_rd_valid <= w_gnt;
      if (w_gnt_found) begin
        r_rd_data <= w_rd_word;
        r_rr      <= w_rr_next;
      end
    end
  end

  assign w_unused_ok = ^{cpu_addr[1:0], w_gnt_addr[1:0]};

  assign cpu_rd   = r_cpu_rd;
  assign cpu_err  = r_cpu_err;
  assign rd_gnt   = w_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc with three read clients: reset, byte
// enables, read-first/forwarding, fairness, out-of-range and mid-run reset.
module tb_data_memory_mc;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int NUM_RD = 3;

  logic                 clk;
  logic                 rst;
  logic                 cpu_we;
  logic [3:0]           cpu_be;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wd;
  logic [31:0]          cpu_rd;
  logic                 cpu_err;
  logic [NUM_RD-1:0]    rd_req;
  logic [NUM_RD*32-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_gnt;
  logic [NUM_RD-1:0]    rd_valid;
  logic [31:0]          rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_RD-1:0] exp_q[$];
  logic [NUM_RD-1:0] exp_g;

  data_memory_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .MEM_INIT("")
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_err(cpu_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    cpu_we   = we;
    cpu_addr = addr;
    cpu_wd   = wd;
    cpu_be   = be;
  endtask

  task automatic client_drive(input int k, input logic req, input logic [31:0] addr);
    rd_req[k]          = req;
    rd_addr[k*32 +: 32] = addr;
  endtask

  initial begin
    rst = 1'b0;
    cpu_drive(1'b0, 32'h0, 32'h0, 4'h0);
    rd_req  = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_RD; i++) client_drive(i, 1'b1, 32'h0000_1000);

    // reset with requests active
    tick(); tick();
    check("rst_cpu_rd",   cpu_rd,   32'h0);
    check("rst_cpu_err",  {31'b0, cpu_err}, 32'h0);
    check("rst_rd_valid", {29'b0, rd_valid}, 32'h0);
    check("rst_rd_data",  rd_data,  32'h0);
    check("rst_rd_gnt",   {29'b0, rd_gnt}, 32'h0);

    rst = 1'b1;
    #1;
    check("first_gnt", {29'b0, rd_gnt}, 32'h1);
    tick();
    check("first_valid", {29'b0, rd_valid}, 32'h1);
    check("oor_client_rst", rd_data, 32'h0);
    rd_req = '0;

    // byte-enable write
    cpu_drive(1'b1, 32'h10, 32'hAABB_CCDD, 4'hF);
    tick();
    cpu_drive(1'b1, 32'h10, 32'h1122_3344, 4'h5);
    tick();
    check("read_first_be", cpu_rd, 32'hAABB_CCDD);
    cpu_drive(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    check("be_merge", cpu_rd, 32'hAA22_CC44);
    check("be_err", {31'b0, cpu_err}, 32'h0);

    // read-first plus full forwarding to client 1 (rr is 1 here)
    cpu_drive(1'b1, 32'h20, 32'h0, 4'hF);
    tick();
    cpu_drive(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    client_drive(1, 1'b1, 32'h20);
    #1;
    check("fwd_gnt", {29'b0, rd_gnt}, 32'h2);
    tick();
    check("fwd_cpu_old", cpu_rd, 32'h0);
    check("fwd_rd_data", rd_data, 32'h1234_5678);
    check("fwd_rd_valid", {29'b0, rd_valid}, 32'h2);

    // partial-lane forwarding to client 2
    client_drive(1, 1'b0, 32'h0);
    cpu_drive(1'b1, 32'h20, 32'h0000_ABCD, 4'h3);
    client_drive(2, 1'b1, 32'h20);
    tick();
    check("pfwd_cpu_old", cpu_rd, 32'h1234_5678);
    check("pfwd_rd_data", rd_data, 32'h1234_ABCD);
    check("pfwd_rd_valid", {29'b0, rd_valid}, 32'h4);

    // hold of rd_data while idle
    client_drive(2, 1'b0, 32'h0);
    cpu_drive(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    check("hold_valid", {29'b0, rd_valid}, 32'h0);
    check("hold_data", rd_data, 32'h1234_ABCD);
    check("pfwd_mem", cpu_rd, 32'h1234_ABCD);

    // fairness: all three clients request for 9 cycles
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    for (int i = 0; i < NUM_RD; i++) client_drive(i, 1'b1, 32'h10);
    for (int i = 0; i < 9; i++) begin
      exp_g = exp_q.pop_front();
      #1;
      check($sformatf("rr_gnt_%0d", i), {29'b0, rd_gnt}, {29'b0, exp_g});
      tick();
      check($sformatf("rr_valid_%0d", i), {29'b0, rd_valid}, {29'b0, exp_g});
      check($sformatf("rr_data_%0d", i), rd_data, 32'hAA22_CC44);
    end
    rd_req = '0;

    // out-of-range CPU write must not alias onto word 0
    cpu_drive(1'b1, 32'h0, 32'h5A5A_5A5A, 4'hF);
    tick();
    cpu_drive(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
    client_drive(0, 1'b1, 32'h1000);
    tick();
    check("oor_err", {31'b0, cpu_err}, 32'h1);
    check("oor_cpu_rd", cpu_rd, 32'h0);
    check("oor_client_data", rd_data, 32'h0);
    check("oor_client_valid", {29'b0, rd_valid}, 32'h1);
    client_drive(0, 1'b0, 32'h0);
    cpu_drive(1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    check("oor_err_pulse", {31'b0, cpu_err}, 32'h0);
    check("oor_no_alias", cpu_rd, 32'h5A5A_5A5A);
    cpu_drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("be0_no_err", {31'b0, cpu_err}, 32'h0);
    check("be0_no_write", cpu_rd, 32'h5A5A_5A5A);

    // reset between a grant and its response (rr is 1 here)
    client_drive(1, 1'b1, 32'h10);
    #1;
    check("mid_gnt", {29'b0, rd_gnt}, 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_gnt_forced", {29'b0, rd_gnt}, 32'h0);
    tick();
    check("mid_no_valid", {29'b0, rd_valid}, 32'h0);
    check("mid_data_clr", rd_data, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < NUM_RD; i++) client_drive(i, 1'b1, 32'h10);
    #1;
    check("post_rst_gnt", {29'b0, rd_gnt}, 32'h1);
    tick();
    check("post_rst_valid", {29'b0, rd_valid}, 32'h1);
    check("post_rst_data", rd_data, 32'hAA22_CC44);
    rd_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
